// File: rtl/minisys_defs.sv
// rtl/minisys_defs.sv - shared Minisys-1A pipeline control definitions
package minisys_defs;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DIV_WAIT  = 2'd1,
        ST_EXC_DRAIN = 2'd2
    } hz_state_t;

    localparam int         DIV_CYCLES_DEF = 32;
    localparam logic [4:0] REG_ZERO       = 5'd0;

endpackage

// File: rtl/hazard_load_use_cmp.sv
// rtl/hazard_load_use_cmp.sv - load-use hazard comparator (EX load vs ID sources)
module hazard_load_use_cmp
    import minisys_defs::*;
(
    input  logic       i_id_uses_rs,
    input  logic       i_id_uses_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_ex_l_type,
    input  logic [4:0] i_ex_wb_addr,
    output logic       o_lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    // $0 is hardwired to zero, so a load targeting it can never feed a consumer.
    always_comb begin
        w_rs_hit = i_id_uses_rs && (i_id_rs == i_ex_wb_addr);
        w_rt_hit = i_id_uses_rt && (i_id_rt == i_ex_wb_addr);
        o_lu     = i_ex_l_type && (i_ex_wb_addr != REG_ZERO) && (w_rs_hit || w_rt_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage Minisys-1A pipeline
module pipeline_hazard_ctrl
    import minisys_defs::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 32
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_l_type,
    input  logic [4:0]        ex_wb_addr,
    input  logic              id_div,
    input  logic              id_hilo_use,
    input  logic              id_redirect,
    input  logic              id_exc,
    input  logic              id_eret,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              exc_redirect,
    output logic              div_busy,
    output logic [PERF_W-1:0] stall_count
);

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_div_cnt;
    logic [PERF_W-1:0] r_stall_count;
    logic              w_lu;
    logic              w_cnt_zero;
    logic              w_cnt_load;
    logic              w_trap;

    hazard_load_use_cmp u_lu_cmp (
        .i_id_uses_rs (id_uses_rs),
        .i_id_uses_rt (id_uses_rt),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_ex_l_type  (ex_l_type),
        .i_ex_wb_addr (ex_wb_addr),
        .o_lu         (w_lu)
    );

    assign w_cnt_zero  = (r_div_cnt == '0);
    assign w_trap      = id_exc || id_eret;
    assign stall_count = r_stall_count;

    // State register; updates on the same edge as the IF/ID and ID/EX registers.
    always_ff @(negedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and divider-start decision.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_trap) begin
                    w_state_nxt = ST_EXC_DRAIN;
                end else if (!w_lu && id_div) begin
                    w_state_nxt = ST_DIV_WAIT;
                    w_cnt_load  = 1'b1;
                end
            end
            ST_DIV_WAIT: begin
                if (w_trap) begin
                    w_state_nxt = ST_EXC_DRAIN;
                end else if (w_cnt_zero) begin
                    // A div waiting in ID issues in the divider's final cycle.
                    if (id_div && !w_lu) begin
                        w_cnt_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_EXC_DRAIN: begin
                w_state_nxt = w_cnt_zero ? ST_RUN : ST_DIV_WAIT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Enables and flushes; reset forces the idle values in the same cycle.
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        exc_redirect   = 1'b0;
        div_busy       = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN, ST_DIV_WAIT: begin
                    div_busy = (r_state == ST_DIV_WAIT);
                    if (w_trap) begin
                        exc_redirect = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end else if (w_lu || (id_hilo_use && !w_cnt_zero && r_state == ST_DIV_WAIT)) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_flush    = 1'b1;
                    end else if (id_div && w_cnt_zero) begin
                        // Divide issues this cycle; it never redirects.
                        if_id_flush = 1'b0;
                    end else if (id_redirect) begin
                        if_id_flush = 1'b1;
                    end
                end
                ST_EXC_DRAIN: begin
                    if_id_flush = 1'b1;
                    div_busy    = !w_cnt_zero;
                end
                default: begin
                    if_id_flush = 1'b0;
                end
            endcase
        end
    end

    // Divide countdown; keeps running through an exception drain.
    always_ff @(negedge clock) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_cnt_load) begin
            r_div_cnt <= CNT_W'(DIV_CYCLES - 1);
        end else if (!w_cnt_zero) begin
            r_div_cnt <= r_div_cnt - CNT_W'(1);
        end
    end

    // Saturating count of cycles in which IF/ID was held.
    always_ff @(negedge clock) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (!if_id_write_en && (r_stall_count != {PERF_W{1'b1}})) begin
            r_stall_count <= r_stall_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int DIV_N  = 4;
    localparam int PERF_N = 4;
    localparam int SC_MAX = (1 << PERF_N) - 1;

    logic              clock;
    logic              reset;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              ex_l_type;
    logic [4:0]        ex_wb_addr;
    logic              id_div;
    logic              id_hilo_use;
    logic              id_redirect;
    logic              id_exc;
    logic              id_eret;
    logic              pc_write_en;
    logic              if_id_write_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              exc_redirect;
    logic              div_busy;
    logic [PERF_N-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(
        .DIV_CYCLES (DIV_N),
        .CNT_W      (6),
        .PERF_W     (PERF_N)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .ex_l_type      (ex_l_type),
        .ex_wb_addr     (ex_wb_addr),
        .id_div         (id_div),
        .id_hilo_use    (id_hilo_use),
        .id_redirect    (id_redirect),
        .id_exc         (id_exc),
        .id_eret        (id_eret),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .exc_redirect   (exc_redirect),
        .div_busy       (div_busy),
        .stall_count    (stall_count)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    // Model: divider cycles remaining, pending drain cycle, stall counter.
    int m_rem   = 0;
    bit m_drain = 1'b0;
    int m_sc    = 0;
    bit m_valid = 1'b0;

    initial begin
        forever begin
            bit e_pc, e_ifw, e_iff, e_idf, e_exc, e_busy, lu, n_drain;
            int n_rem, n_sc;
            logic [5:0] act_v, exp_v;
            @(posedge clock);
            #2;
            lu = ex_l_type && (ex_wb_addr != 5'd0) &&
                 ((id_uses_rs && id_rs == ex_wb_addr) || (id_uses_rt && id_rt == ex_wb_addr));
            e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_exc = 0; e_busy = 0;
            n_rem = (m_rem > 0) ? m_rem - 1 : 0;
            n_drain = 0;
            if (reset) begin
                n_rem = 0;
            end else if (m_drain) begin
                e_iff  = 1;
                e_busy = (m_rem > 1);
            end else begin
                e_busy = (m_rem > 0);
                if (id_exc || id_eret) begin
                    e_exc = 1; e_iff = 1; e_idf = 1; n_drain = 1;
                end else if (lu || (m_rem > 1 && id_hilo_use)) begin
                    e_pc = 0; e_ifw = 0; e_idf = 1;
                end else if (id_div && m_rem <= 1) begin
                    n_rem = DIV_N;
                end else if (id_redirect) begin
                    e_iff = 1;
                end
            end
            if (reset) n_sc = 0;
            else if (!e_ifw && m_sc < SC_MAX) n_sc = m_sc + 1;
            else n_sc = m_sc;
            if (m_valid) begin
                act_v = {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, exc_redirect, div_busy};
                exp_v = {e_pc, e_ifw, e_iff, e_idf, e_exc, e_busy};
                checks++;
                if (act_v !== exp_v || int'(stall_count) != m_sc) begin
                    errors++;
                    $display("FAIL model t=%0t outs(pc,ifw,iff,idf,exc,busy)=%b exp=%b stall_count=%0d exp=%0d",
                             $time, act_v, exp_v, stall_count, m_sc);
                end
            end
            @(negedge clock);
            if (reset) m_valid = 1'b1;
            m_rem   = n_rem;
            m_drain = n_drain;
            m_sc    = n_sc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_l_type = 0; ex_wb_addr = 0; id_div = 0; id_hilo_use = 0;
        id_redirect = 0; id_exc = 0; id_eret = 0;
    endtask

    task automatic set_lu5();
        clear_in();
        ex_l_type = 1; ex_wb_addr = 5; id_rs = 5; id_uses_rs = 1;
    endtask

    initial begin
        reset = 1;
        clear_in();
        step();
        step();
        reset = 0;
        #3;
        chk("rst_pc", pc_write_en, 1);
        chk("rst_ifw", if_id_write_en, 1);
        chk("rst_busy", div_busy, 0);
        chk("rst_sc", stall_count, 0);

        // Load-use on rs
        step(); set_lu5(); #3;
        chk("lu_pc", pc_write_en, 0);
        chk("lu_ifw", if_id_write_en, 0);
        chk("lu_idf", id_ex_flush, 1);
        step(); clear_in(); #3;
        chk("lu_after_pc", pc_write_en, 1);
        chk("lu_sc", stall_count, 1);

        // $0 and unused-source cases, then rt hazard
        step(); clear_in(); ex_l_type = 1; ex_wb_addr = 0; id_rs = 0; id_uses_rs = 1; #3;
        chk("zero_pc", pc_write_en, 1);
        step(); clear_in(); ex_l_type = 1; ex_wb_addr = 7; id_rs = 7; id_rt = 3; id_uses_rt = 1; #3;
        chk("nouse_pc", pc_write_en, 1);
        step(); id_rt = 7; #3;
        chk("rt_ifw", if_id_write_en, 0);
        step(); clear_in(); #3;
        chk("rt_sc", stall_count, 2);

        // Divide, independent add, mflo held then issued
        step(); clear_in(); id_div = 1; id_hilo_use = 1; #3;
        chk("div_issue_busy", div_busy, 0);
        step(); clear_in(); #3;
        chk("div_add_pc", pc_write_en, 1);
        chk("div_add_busy", div_busy, 1);
        for (int i = 0; i < 3; i++) begin
            step(); id_hilo_use = 1; #3;
            chk("mflo_pc", pc_write_en, (i < 2) ? 0 : 1);
            chk("mflo_busy", div_busy, 1);
        end
        step(); clear_in(); #3;
        chk("div_done_busy", div_busy, 0);
        chk("div_sc", stall_count, 4);

        // Divide followed directly by mflo: held 3 cycles
        step(); id_div = 1; id_hilo_use = 1; #3;
        for (int i = 0; i < 4; i++) begin
            step(); clear_in(); id_hilo_use = 1; #3;
            chk("mflo2_pc", pc_write_en, (i < 3) ? 0 : 1);
        end
        step(); clear_in(); #3;
        chk("div2_sc", stall_count, 7);

        // Exception in RUN
        step(); id_exc = 1; #3;
        chk("exc_redir", exc_redirect, 1);
        chk("exc_iff", if_id_flush, 1);
        chk("exc_idf", id_ex_flush, 1);
        step(); clear_in(); #3;
        chk("drain_redir", exc_redirect, 0);
        chk("drain_iff", if_id_flush, 1);
        chk("drain_idf", id_ex_flush, 0);
        step(); #3;
        chk("post_exc_iff", if_id_flush, 0);
        step(); id_eret = 1; #3;
        chk("eret_redir", exc_redirect, 1);
        step(); clear_in(); #3;
        step(); #3;

        // Load-use collides with branch redirect
        step(); set_lu5(); id_redirect = 1; #3;
        chk("coll_pc", pc_write_en, 0);
        chk("coll_iff", if_id_flush, 0);
        step(); clear_in(); id_redirect = 1; #3;
        chk("coll_next_iff", if_id_flush, 1);
        chk("coll_sc", stall_count, 8);

        // Exception while the divider runs
        step(); clear_in(); id_div = 1; #3;
        step(); clear_in(); #3;
        step(); id_exc = 1; #3;
        chk("dexc_busy", div_busy, 1);
        step(); clear_in(); #3;
        chk("dexc_drain_busy", div_busy, 1);
        repeat (4) step();

        // Reset during DIV_WAIT at count 2
        step(); id_div = 1; #3;
        step(); clear_in(); #3;
        step(); reset = 1; #3;
        chk("rst_mid_busy", div_busy, 0);
        step(); reset = 0; #3;
        chk("rst_mid_busy2", div_busy, 0);
        chk("rst_mid_sc", stall_count, 0);

        // Stall counter saturation
        step(); set_lu5();
        repeat (17) step();
        step(); clear_in(); #3;
        chk("sat_sc", stall_count, SC_MAX);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
